// File: rtl/mod_updown_counter.sv
// ---------------------------------------------------------------------------------------------
// mod_updown_counter
//   Parametrised modulo-MODULUS up/down counter with synchronous parallel load, count enable,
//   wrap or saturate at the end of range, a combinational terminal-count output for cascading
//   and a registered one-cycle wrap pulse.
//
// Parameters
//   WIDTH      counter width in bits (1..32)
//   MODULUS    count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   RESET_VAL  value of q_o after reset, < MODULUS
//
// Ports
//   clock_i     sole clock, all state changes on posedge
//   clear_ni    asynchronous active-low reset (deassertion synchronised outside this block)
//   en_i        count enable
//   up_i        1 = count up, 0 = count down
//   load_i      synchronous parallel load, overrides en_i
//   load_val_i  value loaded when load_i=1 (clamped to MODULUS-1)
//   sat_i       1 = saturate at end of range, 0 = wrap
//   q_o         registered count
//   tc_o        terminal count: en_i & (up_i ? q_o==MODULUS-1 : q_o==0)
//   wrap_o      registered pulse, high the cycle after q_o wrapped
//
// Optional feature (macro COUNTER_OVF_STICKY_EN)
//   ovf_clr_i   synchronous clear of the sticky overflow flag
//   ovf_o       sticky flag, set by any wrap or saturation-hold attempt; set beats clear
// ---------------------------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clock_i,
    input  logic             clear_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             sat_i,
`ifdef COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr_i,
    output logic             ovf_o,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             wrap_o
);

    // Terminal values are compared explicitly so MODULUS == 2**WIDTH never relies on overflow.
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ResetQ = WIDTH'(RESET_VAL);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH out of range");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS out of range");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("mod_updown_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] q_d, q_q;
    logic             wrap_d, wrap_q;
    logic             at_max, at_zero;
    logic             sat_hold;
    logic [63:0]      load_val_ext;

    assign at_max       = (q_q == MaxVal);
    assign at_zero      = (q_q == '0);
    assign load_val_ext = 64'(load_val_i);

    always_comb begin
        q_d      = q_q;
        wrap_d   = 1'b0;
        sat_hold = 1'b0;
        if (load_i) begin
            q_d = (load_val_ext >= MODULUS) ? MaxVal : load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (at_max) begin
                    if (sat_i) begin
                        sat_hold = 1'b1;
                    end else begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    if (sat_i) begin
                        sat_hold = 1'b1;
                    end else begin
                        q_d    = MaxVal;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge clear_ni) begin
        if (!clear_ni) begin
            q_q    <= ResetQ;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    logic ovf_d, ovf_q;

    // Set has priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (wrap_d || sat_hold) ovf_d = 1'b1;
    end

    always_ff @(posedge clock_i or negedge clear_ni) begin
        if (!clear_ni) ovf_q <= 1'b0;
        else           ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    logic unused_sat_hold;
    assign unused_sat_hold = sat_hold;
`endif

    // tc ignores sat_i so a chained stage must gate on saturation itself.
    assign tc_o   = en_i & (up_i ? at_max : at_zero);
    assign q_o    = q_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: stimulus pushes expected q/wrap (checked after the next posedge) and
// expected tc (checked just after the inputs change); monitors pop and compare.
// Instances: 0 = MODULUS 16, 1 = MODULUS 10 (shared inputs), 2/3 = cascaded lo/hi stages.
module tb_mod_updown_counter;

    typedef struct {
        int inst;
        int q;
        bit w;
    } exp_t;

    typedef struct {
        int inst;
        bit tc;
    } tc_t;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       s_en = 1'b0, s_up = 1'b1, s_load = 1'b0, s_sat = 1'b0;
    logic [3:0] s_lv = '0;
    logic       c_en = 1'b0;

    logic [3:0] q_a    [4];
    logic       tc_a   [4];
    logic       wrap_a [4];
    logic       ovf_a  [4];

    exp_t qq[$];
    tc_t  tcq[$];
    int   mdl[2];
    int   mods[2] = '{16, 10};
    int   cnt = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mod_updown_counter u_m16 (
        .clock_i(clk), .clear_ni(clear_n), .en_i(s_en), .up_i(s_up), .load_i(s_load),
        .load_val_i(s_lv), .sat_i(s_sat),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clr_i(1'b0), .ovf_o(ovf_a[0]),
`endif
        .q_o(q_a[0]), .tc_o(tc_a[0]), .wrap_o(wrap_a[0])
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_m10 (
        .clock_i(clk), .clear_ni(clear_n), .en_i(s_en), .up_i(s_up), .load_i(s_load),
        .load_val_i(s_lv), .sat_i(s_sat),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clr_i(1'b0), .ovf_o(ovf_a[1]),
`endif
        .q_o(q_a[1]), .tc_o(tc_a[1]), .wrap_o(wrap_a[1])
    );

    mod_updown_counter u_lo (
        .clock_i(clk), .clear_ni(clear_n), .en_i(c_en), .up_i(1'b1), .load_i(1'b0),
        .load_val_i(4'd0), .sat_i(1'b0),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clr_i(1'b0), .ovf_o(ovf_a[2]),
`endif
        .q_o(q_a[2]), .tc_o(tc_a[2]), .wrap_o(wrap_a[2])
    );

    mod_updown_counter u_hi (
        .clock_i(clk), .clear_ni(clear_n), .en_i(tc_a[2]), .up_i(1'b1), .load_i(1'b0),
        .load_val_i(4'd0), .sat_i(1'b0),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clr_i(1'b0), .ovf_o(ovf_a[3]),
`endif
        .q_o(q_a[3]), .tc_o(tc_a[3]), .wrap_o(wrap_a[3])
    );

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: plain integer arithmetic on the documented rules.
    function automatic void step(input int m, input int cur, input bit ld, input bit e,
                                 input bit u, input bit s, input int lv,
                                 output int nxt, output bit w);
        int t;
        nxt = cur;
        w   = 1'b0;
        if (ld) begin
            nxt = (lv > m - 1) ? m - 1 : lv;
        end else if (e) begin
            t = u ? cur + 1 : cur - 1;
            if (t < 0 || t >= m) begin
                if (!s) begin
                    nxt = (t + m) % m;
                    w   = 1'b1;
                end
            end else begin
                nxt = t;
            end
        end
    endfunction

    task automatic drive(input bit ld, input bit e, input bit u, input bit s, input int lv);
        @(negedge clk);
        s_load = ld;
        s_en   = e;
        s_up   = u;
        s_sat  = s;
        s_lv   = 4'(lv);
        for (int i = 0; i < 2; i++) begin
            int nx;
            bit w;
            tcq.push_back('{i, e && (u ? (mdl[i] == mods[i] - 1) : (mdl[i] == 0))});
            step(mods[i], mdl[i], ld, e, u, s, lv, nx, w);
            mdl[i] = nx;
            qq.push_back('{i, nx, w});
        end
    endtask

    task automatic cascade_cycle();
        int lo, hi;
        @(negedge clk);
        c_en = 1'b1;
        lo = cnt % 16;
        hi = (cnt / 16) % 16;
        tcq.push_back('{2, lo == 15});
        tcq.push_back('{3, (lo == 15) && (hi == 15)});
        cnt++;
        qq.push_back('{2, cnt % 16, (cnt % 16) == 0});
        qq.push_back('{3, (cnt / 16) % 16, (cnt % 256) == 0});
    endtask

    // q/wrap monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (qq.size() > 0) begin
                exp_t e;
                e = qq.pop_front();
                check($sformatf("q[%0d]", e.inst), int'(q_a[e.inst]), e.q);
                check($sformatf("wrap[%0d]", e.inst), int'(wrap_a[e.inst]), int'(e.w));
            end
        end
    end

    // tc monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (tcq.size() > 0) begin
                tc_t t;
                t = tcq.pop_front();
                check($sformatf("tc[%0d]", t.inst), int'(tc_a[t.inst]), int'(t.tc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mdl[0] = 0;
        mdl[1] = 0;
        #1;
        check("reset_q0", int'(q_a[0]), 0);
        @(negedge clk);
        clear_n = 1'b1;

        // Load 9, then asynchronous reset in mid-cycle.
        drive(1, 0, 1, 0, 9);
        drive(0, 0, 1, 0, 0);
        @(posedge clk);
        #3;
        clear_n = 1'b0;
        #1;
        mdl[0] = 0;
        mdl[1] = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("async_rst_q[%0d]", i), int'(q_a[i]), 0);
            check($sformatf("async_rst_wrap[%0d]", i), int'(wrap_a[i]), 0);
        end
        s_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_q0", int'(q_a[0]), 0);
        @(negedge clk);
        s_en    = 1'b0;
        clear_n = 1'b1;
        repeat (3) drive(0, 1, 1, 0, 0);

        // Up wrap from 14.
        drive(1, 0, 1, 0, 14);
        repeat (3) drive(0, 1, 1, 0, 0);

        // Down saturate from 1.
        drive(1, 0, 0, 1, 1);
        repeat (3) drive(0, 1, 0, 1, 0);

        // Load priority and clamp, then hold.
        drive(1, 1, 1, 0, 13);
        drive(1, 1, 1, 0, 5);
        repeat (3) drive(0, 0, 1, 0, 0);

        // Direction change, then down-wrap from 0.
        drive(1, 0, 1, 0, 5);
        repeat (2) drive(0, 1, 1, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0);

        // Saturate up at the top of range.
        drive(1, 0, 1, 1, 15);
        repeat (2) drive(0, 1, 1, 1, 0);

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
        drive(0, 0, 1, 0, 0);

        // Two-stage cascade.
        repeat (40) cascade_cycle();
        @(negedge clk);
        c_en = 1'b0;
        check("cascade_total", int'({q_a[3], q_a[2]}), 'h28);

        @(posedge clk);
        #2;
        check("scoreboard_drained", qq.size() + tcq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
